// File: rtl/instr_encoder.sv
// RV64I instruction encoder: packs op/register/immediate fields into a 32-bit word,
// flags illegal field combinations and buffers results in a 2-entry output FIFO.
package instr_encoder_pkg;
    typedef enum logic [5:0] {
        OP_UNKNOWN,
        OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
        OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
        OP_LD, OP_SD,
        OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI,
        OP_SLLI, OP_SRLI, OP_SRAI,
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
        OP_ADDIW, OP_SLLIW, OP_SRLIW, OP_SRAIW,
        OP_ADDW, OP_SUBW, OP_SLLW, OP_SRLW, OP_SRAW
    } decode_op_t;
endpackage

module instr_encoder
    import instr_encoder_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        in_valid,
    output logic        in_ready,
    input  decode_op_t  in_op,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [63:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        out_err,
    input  logic        flush,
    output logic [31:0] enc_count,
    output logic [15:0] err_count
);

    localparam logic [6:0] OPC_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_REG    = 7'b0110011;
    localparam logic [6:0] OPC_IMMW   = 7'b0011011;
    localparam logic [6:0] OPC_REGW   = 7'b0111011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        fits12, fits13, fits21, fits32, shamt6_ok, shamt5_ok;
    logic [31:0] enc_word;
    logic        enc_err;

    always_comb begin
        f3 = 3'b000;
        unique case (in_op)
            OP_SLLI, OP_SLL, OP_SLLIW, OP_SLLW, OP_BNE:     f3 = 3'b001;
            OP_SLTI, OP_SLT:                                f3 = 3'b010;
            OP_SLTIU, OP_SLTU, OP_LD, OP_SD:                f3 = 3'b011;
            OP_XORI, OP_XOR, OP_BLT:                        f3 = 3'b100;
            OP_SRLI, OP_SRAI, OP_SRL, OP_SRA, OP_SRLIW,
            OP_SRAIW, OP_SRLW, OP_SRAW, OP_BGE:             f3 = 3'b101;
            OP_ORI, OP_OR, OP_BLTU:                         f3 = 3'b110;
            OP_ANDI, OP_AND, OP_BGEU:                       f3 = 3'b111;
            default:                                        f3 = 3'b000;
        endcase
    end

    // SRAI's [31:26]=010000 is simply the top six bits of the 0100000 funct7.
    assign f7 = (in_op inside {OP_SUB, OP_SUBW, OP_SRA, OP_SRAW, OP_SRAI, OP_SRAIW})
                ? 7'b0100000 : 7'b0000000;

    // A value fits N signed bits when every bit from N-1 upward matches the sign.
    assign fits12    = (&in_imm[63:11]) | ~(|in_imm[63:11]);
    assign fits13    = (&in_imm[63:12]) | ~(|in_imm[63:12]);
    assign fits21    = (&in_imm[63:20]) | ~(|in_imm[63:20]);
    assign fits32    = (&in_imm[63:31]) | ~(|in_imm[63:31]);
    assign shamt6_ok = ~(|in_imm[63:6]);
    assign shamt5_ok = ~(|in_imm[63:5]);

    always_comb begin
        enc_err  = 1'b0;
        enc_word = 32'h0;
        unique case (in_op)
            OP_LUI, OP_AUIPC: begin
                enc_err  = !fits32 || (in_imm[11:0] != 12'h000);
                enc_word = {in_imm[31:12], in_rd, (in_op == OP_LUI) ? OPC_LUI : OPC_AUIPC};
            end
            OP_JAL: begin
                enc_err  = !fits21 || in_imm[0];
                enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OPC_JAL};
            end
            OP_JALR, OP_LD: begin
                enc_err  = !fits12;
                enc_word = {in_imm[11:0], in_rs1, f3, in_rd,
                            (in_op == OP_JALR) ? OPC_JALR : OPC_LOAD};
            end
            OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
                enc_err  = !fits13 || in_imm[0];
                enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, f3,
                            in_imm[4:1], in_imm[11], OPC_BRANCH};
            end
            OP_SD: begin
                enc_err  = !fits12;
                enc_word = {in_imm[11:5], in_rs2, in_rs1, f3, in_imm[4:0], OPC_STORE};
            end
            OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_ADDIW: begin
                enc_err  = !fits12;
                enc_word = {in_imm[11:0], in_rs1, f3, in_rd,
                            (in_op == OP_ADDIW) ? OPC_IMMW : OPC_IMM};
            end
            OP_SLLI, OP_SRLI, OP_SRAI: begin
                enc_err  = !shamt6_ok;
                enc_word = {f7[6:1], in_imm[5:0], in_rs1, f3, in_rd, OPC_IMM};
            end
            OP_SLLIW, OP_SRLIW, OP_SRAIW: begin
                enc_err  = !shamt5_ok;
                enc_word = {f7, in_imm[4:0], in_rs1, f3, in_rd, OPC_IMMW};
            end
            OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND: begin
                enc_word = {f7, in_rs2, in_rs1, f3, in_rd, OPC_REG};
            end
            OP_ADDW, OP_SUBW, OP_SLLW, OP_SRLW, OP_SRAW: begin
                enc_word = {f7, in_rs2, in_rs1, f3, in_rd, OPC_REGW};
            end
            default: enc_err = 1'b1;
        endcase
        if (enc_err) enc_word = 32'h0;
    end

    logic [1:0]  occ;
    logic [31:0] tail_instr;
    logic        tail_err;
    logic        accept, push, pop;

    assign in_ready  = (occ != 2'd2);
    assign out_valid = (occ != 2'd0);
    assign accept    = in_valid && in_ready;
    assign push      = accept && !flush;
    assign pop       = out_valid && out_ready;

    // Head entry lives directly in the output registers; empty FIFO shows zeros.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            occ        <= 2'd0;
            out_instr  <= 32'h0;
            out_err    <= 1'b0;
            tail_instr <= 32'h0;
            tail_err   <= 1'b0;
        end else if (flush) begin
            occ       <= 2'd0;
            out_instr <= 32'h0;
            out_err   <= 1'b0;
        end else begin
            unique case (occ)
                2'd0: if (push) begin
                    occ       <= 2'd1;
                    out_instr <= enc_word;
                    out_err   <= enc_err;
                end
                2'd1: begin
                    if (push && pop) begin
                        out_instr <= enc_word;
                        out_err   <= enc_err;
                    end else if (push) begin
                        occ        <= 2'd2;
                        tail_instr <= enc_word;
                        tail_err   <= enc_err;
                    end else if (pop) begin
                        occ       <= 2'd0;
                        out_instr <= 32'h0;
                        out_err   <= 1'b0;
                    end
                end
                default: if (pop) begin
                    occ       <= 2'd1;
                    out_instr <= tail_instr;
                    out_err   <= tail_err;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            enc_count <= 32'h0;
            err_count <= 16'h0;
        end else if (accept) begin
            enc_count <= enc_count + 32'd1;
            if (enc_err && (err_count != 16'hFFFF)) err_count <= err_count + 16'd1;
        end
    end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Streaming RV64I instruction encoder: the inverse of the decode-stage decoder. Accepts an operation (the same `decode_op_t` enumeration decode produces) plus register and immediate fields over a valid/ready handshake, packs them into a 32-bit machine word, checks field legality, and buffers results in a 2-entry output FIFO. It feeds instruction RAM preload and self-test program generation, and serves as the golden encoder for decoder round-trip verification.

## Interface
- No parameters. FIFO depth is fixed at 2.
- `clk`  in  1  clock; all state updates on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  request accepted when `in_valid && in_ready`.
- `in_op`  in  `decode_op_t`  operation to encode.
- `in_rd`, `in_rs1`, `in_rs2`  in  5 each  register indices.
- `in_imm`  in  64  signed immediate; shift amount for shift ops.
- `out_valid`  out  1  FIFO head valid.
- `out_ready`  in  1  consumer pops the head when `out_valid && out_ready`.
- `out_instr`  out  32  encoded word, `u32`.
- `out_err`  out  1  head entry is illegal; `out_instr` = 32'h0000_0000.
- `flush`  in  1  synchronous FIFO clear.
- `enc_count`  out  32  accepted requests, wraps modulo 2^32.
- `err_count`  out  16  erroneous requests, saturates at 16'hFFFF.

## Operation
- Field placement per RV64I: rd[11:7], funct3[14:12], rs1[19:15], rs2[24:20], funct7[31:25].
- Opcodes:
  - I-ALU 0010011, R 0110011, IW 0011011, RW 0111011
  - LUI 0110111, AUIPC 0010111
  - LD 0000011 (f3 011), SD 0100011 (f3 011)
  - JAL 1101111, JALR 1100111 (f3 000), branch 1100011
- Funct3 values:
  - ADD/SUB 000, SLL 001, SLT 010, SLTU 011, XOR 100, SRL/SRA 101, OR 110, AND 111.
  - BEQ 000, BNE 001, BLT 100, BGE 101, BLTU 110, BGEU 111.
- Funct7: SUB, SUBW, SRA and SRAW use 0100000; all other R/RW ops use 0000000.
- SLLI/SRLI/SRAI: [31:26] = 000000 or 010000 (SRAI), shamt[25:20] in 0..63.
- SLLIW/SRLIW/SRAIW: funct7 = 0000000 or 0100000 (SRAIW), shamt[24:20] in 0..31, bit 25 = 0.
- Immediate formats:
  - I (ALU imm, LD, JALR): imm[11:0] -> [31:20].
  - S: imm[11:5] -> [31:25], imm[4:0] -> [11:7].
  - B: imm[12|10:5] -> [31:25], imm[4:1|11] -> [11:7].
  - U: imm[31:12] -> [31:12].
  - J: imm[20|10:1|11|19:12] -> [31:12].
- Legality. A request is an error if any of these holds:
  - I/S imm outside -2048..2047.
  - B imm outside -4096..4094, or imm[0] = 1.
  - J imm outside -1048576..1048574, or imm[0] = 1.
  - U imm[11:0] != 0, or imm not equal to the sign-extension of imm[31:0].
  - Shamt out of range (negative values included).
  - `in_op` = UNKNOWN or any op outside the list above.
- Error entries: `out_err` = 1, `out_instr` = 0. Both counters increment.
- Fields unused by an op are ignored and never cause an error; e.g. rs2 for ADDI, rd for SD.

## Timing
- Reset values: FIFO empty, `out_valid` 0, `out_instr` 0, `out_err` 0, `in_ready` 1, both counters 0.
- Encode is combinational into the FIFO write port. Latency from accept to `out_valid` is 1 cycle when the FIFO is empty.
- `in_ready` = (occupancy != 2), driven from registered state only. There is no combinational path from `out_ready` to `in_ready`.
- Push and pop in the same cycle:
  - occupancy 1: stays 1, head advances to the new entry.
  - occupancy 2: push cannot occur (`in_ready` = 0); pop leaves 1.
- FIFO order is strict FIFO. `out_instr`/`out_err` are stable while `out_valid && !out_ready`.
- `flush` clears occupancy to 0 next cycle and drops any same-cycle push. Counters still count a request accepted in a flush cycle.
- `resetn` low mid-operation clears all state immediately, regardless of `clk`.

## Test plan
- `in_op`=ADDI, rd=1, rs1=0, imm=-1 -> `out_instr` 32'hFFF00093 one cycle after accept, `out_err`=0, `enc_count`=1.
- Round trip: for each op, encode random legal fields and feed `out_instr` into the decoder -> decoded op, dst and regwrite match the request (regwrite=0 when rd=0).
- BEQ rs1=1, rs2=2, imm=-4 -> 32'hFE208EE3. BEQ with imm=3 -> `out_err`=1, `out_instr`=0, `err_count`=1.
- SRAI rd=5, rs1=5, shamt=63 -> 32'h43F2D293. SRAIW with shamt=32 -> error.
- Backpressure: hold `out_ready`=0 and offer 3 requests -> exactly 2 accepted, `in_ready`=0. Then raise `out_ready` -> words emerge in order, and the third is accepted the cycle after the first pop.
- Assert `flush` with 2 entries buffered -> `out_valid`=0 next cycle. Pulse `resetn` low mid-stream -> all outputs return to their reset values asynchronously.
